// File: rtl/fp_pkg.sv
// Shared IEEE-754 field helpers for the FP datapath (fadd, fp_to_int, ...).
// Types and functions only, no logic.
// Not applicable (no handshake).
package fp_pkg;

  // Widest unbiased exponent (binary64 spans -1023..1024) and widest mantissa incl. hidden bit.
  localparam int EXP_W = 13;
  localparam int MAN_W = 53;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_DENORM,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  // Format-independent unpacked operand: exp is unbiased, man carries the hidden bit
  // at position man_len(N) and is zero above it.
  typedef struct packed {
    logic                    sign;
    logic signed [EXP_W-1:0] exp;
    logic [MAN_W-1:0]        man;
  } fp_unpacked_t;

  function automatic int exp_len(input int n);
    return (n == 64) ? 11 : 8;
  endfunction

  function automatic int man_len(input int n);
    return (n == 64) ? 52 : 23;
  endfunction

  function automatic int bias(input int n);
    return (1 << (exp_len(n) - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Classify an IEEE-754 operand and split it into sign / unbiased exponent / mantissa.
// Purely combinational, zero latency.
// No handshake; the instantiating stage owns flow control.
module fp_unpack
  import fp_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]  a,
  output fp_unpacked_t  u,
  output fp_class_e     cls
);

  localparam int EL = exp_len(N);
  localparam int ML = man_len(N);
  localparam logic [EXP_W-1:0] BIAS_V = EXP_W'(bias(N));

  logic [EL-1:0] exp_f;
  logic [ML-1:0] frac_f;
  logic          exp_ones;
  logic          exp_zero;
  logic          frac_zero;

  assign exp_f  = a[N-2:ML];
  assign frac_f = a[ML-1:0];

  // Field split plus class decode; the hidden bit is set only for normals.
  always_comb begin
    exp_ones  = &exp_f;
    exp_zero  = ~|exp_f;
    frac_zero = ~|frac_f;
    u.sign    = a[N-1];
    u.exp     = EXP_W'({1'b0, exp_f}) - BIAS_V;
    u.man     = MAN_W'({~exp_zero, frac_f});
    if (exp_ones) begin
      cls = frac_zero ? FP_INF : FP_NAN;
    end else if (exp_zero) begin
      cls = frac_zero ? FP_ZERO : FP_DENORM;
    end else begin
      cls = FP_NORM;
    end
  end

endmodule

// File: rtl/fp_to_int.sv
// IEEE-754 float -> saturating signed integer with invalid/inexact flags (FP_TO_INT_RNE_EN: round-to-nearest-even, else truncate).
// Two register stages: result valid 2 cycles after input handshake, 1 result/cycle.
// Stalled output holds result/flags; stage 1 holds while stage 2 is blocked, in_ready drops only then.
module fp_to_int
  import fp_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         invalid,
  output logic         inexact
);

  localparam int ML = man_len(N);
  // Mantissa placed in a fixed-point vector with ML fraction bits, shifted left by e.
  localparam int W  = MAN_W + N;
  localparam int IW = W - ML;
  // One extra bit so a rounding carry is visible to the range check.
  localparam int MW = IW + 1;

  localparam logic [MW-1:0] LIM_POS = {{(MW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [MW-1:0] LIM_NEG = {{(MW-N){1'b0}}, 1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]  SAT_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  SAT_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [EXP_W-1:0] E_TOP = EXP_W'(N-1);
  localparam logic signed [EXP_W-1:0] E_M1  = {EXP_W{1'b1}};

  if (N != 32 && N != 64) begin : g_bad_n
    $error("fp_to_int: N must be 32 or 64");
  end

  fp_unpacked_t un_u;
  fp_class_e    un_cls;

  fp_unpack #(.N(N)) u_unpack (
    .a   (a),
    .u   (un_u),
    .cls (un_cls)
  );

  logic         s1_valid;
  fp_unpacked_t s1_u;
  fp_class_e    s1_cls;
  logic         s2_advance;

  assign s2_advance = ~out_valid | out_ready;
  assign in_ready   = ~s1_valid | s2_advance;

  // Stage 1 valid bit: refills whenever the stage is free or draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // Stage 1 payload: captured only on an accepted operand.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      s1_u   <= un_u;
      s1_cls <= un_cls;
    end
  end

  logic signed [EXP_W-1:0] e;
  logic [W-1:0]            shifted;
  logic [IW-1:0]           int_part;
  logic [ML-1:0]           frac_bits;
  logic [MW-1:0]           mag;
  logic                    ovf;
  logic [N-1:0]            res_c;
  logic                    inv_c;
  logic                    inx_c;
`ifdef FP_TO_INT_RNE_EN
  logic                    guard;
  logic                    sticky;
  logic                    round_up;
`endif

  assign e = s1_u.exp;

  // Stage 2: shift to integer, optional rounding, range check, saturate and negate.
  always_comb begin
    // Low exponent bits suffice: the shifted value is only used for 0 <= e <= N-2.
    shifted   = {{N{1'b0}}, s1_u.man} << e[5:0];
    int_part  = shifted[W-1:ML];
    frac_bits = shifted[ML-1:0];
`ifdef FP_TO_INT_RNE_EN
    guard     = frac_bits[ML-1];
    sticky    = |frac_bits[ML-2:0];
    round_up  = guard & (sticky | int_part[0]);
`endif
    mag   = '0;
    ovf   = 1'b0;
    res_c = '0;
    inv_c = 1'b0;
    inx_c = 1'b0;
    case (s1_cls)
      FP_ZERO: begin
        res_c = '0;
      end
      FP_DENORM: begin
        inx_c = 1'b1;
      end
      FP_NAN: begin
        res_c = SAT_POS;
        inv_c = 1'b1;
      end
      FP_INF: begin
        res_c = s1_u.sign ? SAT_NEG : SAT_POS;
        inv_c = 1'b1;
      end
      default: begin
        if (e[EXP_W-1]) begin
          // |value| < 1: only the fraction survives.
          inx_c = 1'b1;
`ifdef FP_TO_INT_RNE_EN
          // (0.5, 1) rounds up; exactly 0.5 ties to even zero.
          if (e == E_M1 && |s1_u.man[ML-1:0]) begin
            mag = MW'(1);
          end
`endif
        end else if (e >= E_TOP) begin
          // The only representable value here is exactly -2**(N-1).
          if (s1_u.sign && e == E_TOP && s1_u.man[ML-1:0] == '0) begin
            mag = LIM_NEG;
          end else begin
            ovf = 1'b1;
          end
        end else begin
          mag   = MW'(int_part);
          inx_c = |frac_bits;
`ifdef FP_TO_INT_RNE_EN
          mag   = mag + MW'(round_up);
`endif
        end
        if (ovf || mag > (s1_u.sign ? LIM_NEG : LIM_POS)) begin
          res_c = s1_u.sign ? SAT_NEG : SAT_POS;
          inv_c = 1'b1;
          inx_c = 1'b0;
        end else begin
          res_c = s1_u.sign ? -mag[N-1:0] : mag[N-1:0];
        end
      end
    endcase
  end

  // Stage 2 / output register: advances when empty or the consumer takes the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      invalid   <= 1'b0;
      inexact   <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result  <= res_c;
        invalid <= inv_c;
        inexact <= inx_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_to_int.sv
// Randomized + directed bench for fp_to_int (N=32) against an integer-arithmetic reference model.
// Honours FP_TO_INT_RNE_EN in its expectations.
// Drives random backpressure and checks hold-stability, ordering and reset flush.
module tb_fp_to_int;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        invalid;
  logic        inexact;

  int total = 0;
  int bad   = 0;
  bit saw_in_block;

  typedef struct {
    logic [31:0] a;
    logic [33:0] exp;
  } item_t;

  item_t pend_q[$];
  item_t fly_q[$];

  fp_to_int #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .invalid   (invalid),
    .inexact   (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Reference: value = m * 2**(e-23); integer quotient/remainder, then round and range-check.
  function automatic logic [33:0] ref_model(input logic [31:0] x);
    int                ex;
    int                e;
    int                sh;
    bit                s;
    bit                up;
    bit                inx;
    longint unsigned   m;
    longint unsigned   q;
    longint unsigned   rem;
    longint unsigned   half;
    longint unsigned   mag;
    longint unsigned   lim;
    logic [31:0]       r;
    s  = x[31];
    ex = int'(x[30:23]);
    if (ex == 255) begin
      if (x[22:0] != 0) return {32'h7FFFFFFF, 2'b10};
      return s ? {32'h80000000, 2'b10} : {32'h7FFFFFFF, 2'b10};
    end
    if (ex == 0) return {32'h0, 1'b0, (x[22:0] != 0)};
    m  = 64'h800000 | 64'(x[22:0]);
    e  = ex - 127;
    up = 1'b0;
    if (e > 40) begin
      q   = 64'd1 << 40;
      rem = 0;
    end else if (e >= 23) begin
      q   = m << (e - 23);
      rem = 0;
    end else begin
      sh = 23 - e;
      if (sh >= 48) begin
        q   = 0;
        rem = 1;
      end else begin
        q    = m >> sh;
        rem  = m - (q << sh);
        half = 64'd1 << (sh - 1);
`ifdef FP_TO_INT_RNE_EN
        up = (rem > half) || (rem == half && q[0]);
`endif
      end
    end
    inx = (rem != 0);
    mag = q + 64'(up);
    lim = s ? 64'h80000000 : 64'h7FFFFFFF;
    if (mag > lim) return s ? {32'h80000000, 2'b10} : {32'h7FFFFFFF, 2'b10};
    r = s ? 32'(-mag) : 32'(mag);
    return {r, 1'b0, inx};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] x;
    int          k;
    x = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: x[30:23] = 8'hFF;
      1: x[30:23] = 8'h00;
      2: begin
        x[30:23] = 8'($urandom_range(120, 160));
        x[21:0]  = '0;
      end
      3, 4, 5, 6, 7: x[30:23] = 8'($urandom_range(110, 160));
      default: ;
    endcase
    return x;
  endfunction

  // mode 0: out_ready=1; mode 1: random in_valid/out_ready; mode 2: out_ready low for cycles 3..5.
  task automatic stream(input int mode);
    int          cyc;
    int          budget;
    logic        held_v;
    logic [33:0] held;
    cyc    = 0;
    budget = 60 + 4 * pend_q.size();
    held_v = 1'b0;
    held   = '0;
    while ((pend_q.size() > 0 || fly_q.size() > 0) && cyc < budget) begin
      @(negedge clk);
      in_valid = (pend_q.size() > 0) && (mode != 1 || $urandom_range(0, 3) != 0);
      a        = (pend_q.size() > 0) ? pend_q[0].a : 32'h0;
      case (mode)
        1:       out_ready = ($urandom_range(0, 2) != 0);
        2:       out_ready = !(cyc >= 3 && cyc <= 5);
        default: out_ready = 1'b1;
      endcase
      #4;
      if (held_v) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'({result, invalid, inexact}), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (fly_q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          check($sformatf("res a=%h", fly_q[0].a), 64'({result, invalid, inexact}), 64'(fly_q[0].exp));
          void'(fly_q.pop_front());
        end
      end
      held_v = out_valid && !out_ready;
      held   = {result, invalid, inexact};
      if (!in_ready) saw_in_block = 1'b1;
      if (in_valid && in_ready) fly_q.push_back(pend_q.pop_front());
      cyc++;
    end
    check("drained", 64'(pend_q.size() + fly_q.size()), 64'd0);
    pend_q.delete();
    fly_q.delete();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [31:0] dir_a [18] = '{
    32'h3F800000, 32'hC0600000, 32'h40200000, 32'hCF000000, 32'h4F000000, 32'h7FC00000,
    32'hFF800000, 32'h00000001, 32'h80000000, 32'h3F000000, 32'h3F400000, 32'h4EFFFFFF,
    32'hCF000001, 32'h7F800000, 32'h3FC00000, 32'hBF400000, 32'hFF800001, 32'hCEFFFFFF};
`ifdef FP_TO_INT_RNE_EN
  logic [33:0] dir_e [18] = '{
    {32'h00000001, 2'b00}, {32'hFFFFFFFC, 2'b01}, {32'h00000002, 2'b01}, {32'h80000000, 2'b00},
    {32'h7FFFFFFF, 2'b10}, {32'h7FFFFFFF, 2'b10}, {32'h80000000, 2'b10}, {32'h00000000, 2'b01},
    {32'h00000000, 2'b00}, {32'h00000000, 2'b01}, {32'h00000001, 2'b01}, {32'h7FFFFF80, 2'b00},
    {32'h80000000, 2'b10}, {32'h7FFFFFFF, 2'b10}, {32'h00000002, 2'b01}, {32'hFFFFFFFF, 2'b01},
    {32'h7FFFFFFF, 2'b10}, {32'h80000080, 2'b00}};
`else
  logic [33:0] dir_e [18] = '{
    {32'h00000001, 2'b00}, {32'hFFFFFFFD, 2'b01}, {32'h00000002, 2'b01}, {32'h80000000, 2'b00},
    {32'h7FFFFFFF, 2'b10}, {32'h7FFFFFFF, 2'b10}, {32'h80000000, 2'b10}, {32'h00000000, 2'b01},
    {32'h00000000, 2'b00}, {32'h00000000, 2'b01}, {32'h00000000, 2'b01}, {32'h7FFFFF80, 2'b00},
    {32'h80000000, 2'b10}, {32'h7FFFFFFF, 2'b10}, {32'h00000001, 2'b01}, {32'h00000000, 2'b01},
    {32'h7FFFFFFF, 2'b10}, {32'h80000080, 2'b00}};
`endif

  initial begin
    item_t it;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 32'h0;
    saw_in_block = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #4;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'({invalid, inexact}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Latency: 1.0 accepted at the first edge, visible two cycles later.
    @(negedge clk);
    in_valid  = 1'b1;
    a         = 32'h3F800000;
    out_ready = 1'b1;
    #4;
    check("lat_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #4;
    check("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    #4;
    check("lat_cycle2_valid", 64'(out_valid), 64'd1);
    check("lat_cycle2_data", 64'({result, invalid, inexact}), 64'({32'h1, 2'b00}));

    // Directed corner values, full throughput.
    for (int i = 0; i < 18; i++) begin
      it.a = dir_a[i];
      it.exp = dir_e[i];
      pend_q.push_back(it);
    end
    stream(0);

    // Four back-to-back operands with a 3-cycle consumer stall mid-stream.
    saw_in_block = 1'b0;
    for (int i = 0; i < 4; i++) begin
      it.a = 32'h3F800000 + (32'(i) << 23);
      it.exp = {32'(i + 1) << i >> i, 2'b00};
      pend_q.push_back(it);
    end
    pend_q[2].exp = {32'h4, 2'b00};
    pend_q[3].exp = {32'h8, 2'b00};
    stream(2);
    check("stall_in_ready_low", 64'(saw_in_block), 64'd1);

    // Random operands with random backpressure, then at full rate.
    for (int i = 0; i < 300; i++) begin
      it.a = rand_operand();
      it.exp = ref_model(it.a);
      pend_q.push_back(it);
    end
    stream(1);
    for (int i = 0; i < 100; i++) begin
      it.a = rand_operand();
      it.exp = ref_model(it.a);
      pend_q.push_back(it);
    end
    stream(0);

    // Reset with two operands in flight: neither may emerge.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 32'h40400000;
    @(negedge clk);
    a = 32'h40A00000;
    @(negedge clk);
    in_valid = 1'b0;
    #4;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #4;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_result", 64'(result), 64'd0);
    check("flush_flags", 64'({invalid, inexact}), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #4;
      check("flush_no_ghost", 64'(out_valid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
